// File: rtl/mem_req_scheduler.sv
// mem_req_scheduler: shares one L2 port between icache line fills and dcache
// fills/write-backs. One transaction is in flight at a time. The dcache wins
// ties, but an icache request is granted after at most STARVE_MAX dcache grants.
module mem_req_scheduler #(
   parameter int STARVE_MAX = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_read,
   input  logic [31:0]  i_address,
   output logic         i_resp,
   output logic [255:0] i_rdata,
   input  logic         d_read,
   input  logic         d_write,
   input  logic [31:0]  d_address,
   input  logic [255:0] d_wdata,
   output logic         d_resp,
   output logic [255:0] d_rdata,
   output logic         l2_read,
   output logic         l2_write,
   output logic [31:0]  l2_address,
   output logic [255:0] l2_wdata,
   input  logic         l2_resp,
   input  logic [255:0] l2_rdata
);

   typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D} state_t;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   state_t     state;
   logic [3:0] starve_cnt;
   logic       d_want;
   logic       grant_i;
   logic       grant_d;

   // Arbitration, evaluated only in IDLE: dcache wins a tie unless icache has starved
   always_comb begin
      d_want  = d_read | d_write;
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (state == IDLE) begin
         grant_i = i_read & (~d_want | (starve_cnt == STARVE_LIM));
         grant_d = d_want & ~grant_i;
      end
   end

   // Scheduler FSM: fairness counter, captured L2 request and registered responses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         starve_cnt <= 4'd0;
         l2_read    <= 1'b0;
         l2_write   <= 1'b0;
         l2_address <= 32'd0;
         l2_wdata   <= 256'd0;
         i_resp     <= 1'b0;
         d_resp     <= 1'b0;
         i_rdata    <= 256'd0;
         d_rdata    <= 256'd0;
      end else begin
         // completion pulses last exactly one cycle
         i_resp <= 1'b0;
         d_resp <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_i) begin
                  state      <= BUSY_I;
                  l2_read    <= 1'b1;
                  l2_write   <= 1'b0;
                  l2_address <= i_address;
                  starve_cnt <= 4'd0;
               end else if (grant_d) begin
                  // a simultaneous read and write is served as the write-back
                  state      <= BUSY_D;
                  l2_read    <= ~d_write;
                  l2_write   <= d_write;
                  l2_address <= d_address;
                  l2_wdata   <= d_wdata;
                  if (!i_read) begin
                     starve_cnt <= 4'd0;
                  end else if (starve_cnt != STARVE_LIM) begin
                     starve_cnt <= starve_cnt + 4'd1;
                  end
               end
            end
            BUSY_I: begin
               if (l2_resp) begin
                  state   <= DONE_I;
                  l2_read <= 1'b0;
                  i_rdata <= l2_rdata;
                  i_resp  <= 1'b1;
               end
            end
            BUSY_D: begin
               if (l2_resp) begin
                  state    <= DONE_D;
                  l2_read  <= 1'b0;
                  l2_write <= 1'b0;
                  // a write-back returns no data, so the last fill line is kept
                  if (!l2_write) begin
                     d_rdata <= l2_rdata;
                  end
                  d_resp   <= 1'b1;
               end
            end
            DONE_I, DONE_D: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_req_scheduler.sv
// tb_mem_req_scheduler: table-driven basic transactions, hand-written corner
// sequences (starvation order, dropped request, reset mid-transaction) and a
// randomized run against a transaction-level reference model.
module tb_mem_req_scheduler;

   localparam int STARVE = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         i_read = 1'b0;
   logic [31:0]  i_address = '0;
   logic         i_resp;
   logic [255:0] i_rdata;
   logic         d_read = 1'b0;
   logic         d_write = 1'b0;
   logic [31:0]  d_address = '0;
   logic [255:0] d_wdata = '0;
   logic         d_resp;
   logic [255:0] d_rdata;
   logic         l2_read;
   logic         l2_write;
   logic [31:0]  l2_address;
   logic [255:0] l2_wdata;
   logic         l2_resp = 1'b0;
   logic [255:0] l2_rdata = '0;

   int nvec = 0;
   int nerr = 0;

   // reference model: one outstanding transaction plus a completion cycle
   bit           m_busy, m_done, m_wr, m_is_d;
   int           m_waits;
   logic [31:0]  m_addr;
   logic [255:0] m_wdata, e_irdata, e_drdata;
   bit           e_iresp, e_dresp;

   typedef struct {
      bit          ir, dr, dw, rsp;
      bit          e_rd, e_wr, e_ir, e_dr;
      logic [31:0] e_addr;
   } vec_t;

   vec_t tbl[12];

   mem_req_scheduler #(.STARVE_MAX(STARVE)) dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_resp(d_resp), .d_rdata(d_rdata),
      .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address), .l2_wdata(l2_wdata),
      .l2_resp(l2_resp), .l2_rdata(l2_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk_b(input string name, input logic act, input logic exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk_w(input string name, input logic [255:0] act, input logic [255:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      i_read  = 1'b0;
      d_read  = 1'b0;
      d_write = 1'b0;
      l2_resp = 1'b0;
   endtask

   task automatic model_reset();
      m_busy = 0; m_done = 0; m_wr = 0; m_is_d = 0; m_waits = 0;
      m_addr = '0; m_wdata = '0; e_irdata = '0; e_drdata = '0;
      e_iresp = 0; e_dresp = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      tick();
      tick();
      rst = 1'b0;
      model_reset();
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   // advance the model by one clock edge using the inputs currently applied
   task automatic model_step();
      bit want_d;
      want_d  = d_read | d_write;
      e_iresp = 0;
      e_dresp = 0;
      if (m_done) begin
         m_done = 0;
      end else if (m_busy) begin
         if (l2_resp) begin
            m_busy = 0;
            m_done = 1;
            if (m_is_d) begin
               e_dresp = 1;
               if (!m_wr) e_drdata = l2_rdata;
            end else begin
               e_iresp  = 1;
               e_irdata = l2_rdata;
            end
         end
      end else if (i_read && (!want_d || m_waits == STARVE)) begin
         m_busy = 1; m_is_d = 0; m_wr = 0; m_addr = i_address; m_waits = 0;
      end else if (want_d) begin
         m_busy = 1; m_is_d = 1; m_wr = d_write; m_addr = d_address; m_wdata = d_wdata;
         m_waits = i_read ? ((m_waits < STARVE) ? m_waits + 1 : STARVE) : 0;
      end
   endtask

   task automatic check_model(input int c);
      chk_b($sformatf("rnd%0d_l2_read", c), l2_read, m_busy && !m_wr);
      chk_b($sformatf("rnd%0d_l2_write", c), l2_write, m_busy && m_wr);
      chk_b($sformatf("rnd%0d_i_resp", c), i_resp, e_iresp);
      chk_b($sformatf("rnd%0d_d_resp", c), d_resp, e_dresp);
      chk_w($sformatf("rnd%0d_i_rdata", c), i_rdata, e_irdata);
      chk_w($sformatf("rnd%0d_d_rdata", c), d_rdata, e_drdata);
      if (m_busy) chk_w($sformatf("rnd%0d_l2_address", c), 256'(l2_address), 256'(m_addr));
      if (m_busy && m_wr) chk_w($sformatf("rnd%0d_l2_wdata", c), l2_wdata, m_wdata);
   endtask

   initial begin
      logic [255:0] line_a5, line_wd, line_rd;
      logic [31:0]  order[10];
      int           g;
      bit           prev;

      line_a5 = {32{8'hA5}};
      line_wd = {8{32'h1234_5678}};
      line_rd = {8{32'hDEAD_BEEF}};

      // ---------------- reset state, asynchronous, before any clock edge
      #1 rst = 1'b1;
      #1;
      chk_b("rst_l2_read", l2_read, 1'b0);
      chk_b("rst_l2_write", l2_write, 1'b0);
      chk_b("rst_i_resp", i_resp, 1'b0);
      chk_b("rst_d_resp", d_resp, 1'b0);
      chk_w("rst_l2_address", 256'(l2_address), 256'd0);
      chk_w("rst_l2_wdata", l2_wdata, 256'd0);
      chk_w("rst_i_rdata", i_rdata, 256'd0);
      chk_w("rst_d_rdata", d_rdata, 256'd0);

      // ---------------- table: icache fill, dcache write-back, spurious l2_resp
      //                   ir    dr    dw    rsp   e_rd  e_wr  e_ir  e_dr  e_addr
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0060};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0060};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0060};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0060};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
      tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
      tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0020};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0020};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};

      do_reset();
      i_address = 32'h0000_0060;
      d_address = 32'h8000_0020;
      d_wdata   = line_wd;
      l2_rdata  = line_a5;
      for (int i = 0; i < 12; i++) begin
         i_read  = tbl[i].ir;
         d_read  = tbl[i].dr;
         d_write = tbl[i].dw;
         l2_resp = tbl[i].rsp;
         tick();
         chk_b($sformatf("tbl%0d_l2_read", i), l2_read, tbl[i].e_rd);
         chk_b($sformatf("tbl%0d_l2_write", i), l2_write, tbl[i].e_wr);
         chk_b($sformatf("tbl%0d_i_resp", i), i_resp, tbl[i].e_ir);
         chk_b($sformatf("tbl%0d_d_resp", i), d_resp, tbl[i].e_dr);
         if (tbl[i].e_rd || tbl[i].e_wr)
            chk_w($sformatf("tbl%0d_l2_address", i), 256'(l2_address), 256'(tbl[i].e_addr));
         if (tbl[i].e_wr) chk_w($sformatf("tbl%0d_l2_wdata", i), l2_wdata, line_wd);
         if (tbl[i].e_ir) chk_w($sformatf("tbl%0d_i_rdata", i), i_rdata, line_a5);
      end
      chk_w("tbl_i_rdata_held", i_rdata, line_a5);
      chk_w("tbl_d_rdata_after_write", d_rdata, 256'd0);

      // ---------------- starvation: both requesters always asking, 1-cycle L2
      do_reset();
      i_address = 32'h0000_0100;
      d_address = 32'h0000_0200;
      i_read = 1'b1;
      d_read = 1'b1;
      g = 0;
      prev = 1'b0;
      for (int k = 0; k < 10; k++) order[k] = '0;
      for (int c = 0; c < 200 && g < 10; c++) begin
         tick();
         if (l2_read && !prev) begin
            order[g] = l2_address;
            g++;
         end
         prev = l2_read;
         l2_resp = l2_read;
      end
      chk_w("starve_grant_count", 256'(g), 256'(10));
      for (int k = 0; k < 10; k++)
         chk_w($sformatf("starve_order%0d", k), 256'(order[k]),
               (k % 5 == 4) ? 256'(32'h100) : 256'(32'h200));

      // ---------------- reset in BUSY_D after four dcache grants with icache waiting
      do_reset();
      i_read = 1'b1;
      d_read = 1'b1;
      g = 0;
      prev = 1'b0;
      for (int c = 0; c < 100 && g < 4; c++) begin
         tick();
         if (l2_read && !prev) g++;
         prev = l2_read;
         l2_resp = l2_read && (g < 4);
      end
      chk_w("rstbusy_grants", 256'(g), 256'(4));
      chk_b("rstbusy_pre_l2_read", l2_read, 1'b1);
      #2 rst = 1'b1;
      l2_resp = 1'b1;
      #1;
      chk_b("rstbusy_async_l2_read", l2_read, 1'b0);
      chk_w("rstbusy_async_l2_address", 256'(l2_address), 256'd0);
      tick();
      chk_b("rstbusy_d_resp_a", d_resp, 1'b0);
      tick();
      chk_b("rstbusy_d_resp_b", d_resp, 1'b0);
      rst = 1'b0;
      l2_resp = 1'b0;
      tick();
      // counter cleared by reset: dcache wins again instead of the starved icache
      chk_b("rstbusy_post_l2_read", l2_read, 1'b1);
      chk_w("rstbusy_post_address", 256'(l2_address), 256'(32'h200));
      chk_b("rstbusy_post_d_resp", d_resp, 1'b0);

      // ---------------- dcache drops its request right after grant
      do_reset();
      l2_rdata  = line_rd;
      d_address = 32'h0000_0300;
      i_address = 32'h0000_0400;
      d_read = 1'b1;
      tick();
      chk_b("drop_l2_read_c1", l2_read, 1'b1);
      chk_w("drop_addr_c1", 256'(l2_address), 256'(32'h300));
      d_read = 1'b0;
      i_read = 1'b1;
      tick();
      chk_b("drop_l2_read_c2", l2_read, 1'b1);
      chk_w("drop_addr_c2", 256'(l2_address), 256'(32'h300));
      l2_resp = 1'b1;
      tick();
      chk_b("drop_l2_read_c3", l2_read, 1'b0);
      chk_b("drop_d_resp_c3", d_resp, 1'b1);
      chk_w("drop_d_rdata_c3", d_rdata, line_rd);
      l2_resp = 1'b0;
      tick();
      chk_b("drop_d_resp_c4", d_resp, 1'b0);
      chk_b("drop_l2_read_c4", l2_read, 1'b0);
      tick();
      chk_b("drop_l2_read_c5", l2_read, 1'b1);
      chk_w("drop_addr_c5", 256'(l2_address), 256'(32'h400));
      i_read = 1'b0;
      l2_resp = 1'b1;
      tick();
      chk_b("drop_i_resp_c6", i_resp, 1'b1);
      chk_w("drop_i_rdata_c6", i_rdata, line_rd);
      l2_resp = 1'b0;

      // ---------------- randomized run against the reference model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         i_read    = ($urandom_range(0, 99) < 60);
         d_read    = ($urandom_range(0, 99) < 45);
         d_write   = ($urandom_range(0, 99) < 25);
         i_address = $urandom;
         d_address = $urandom;
         d_wdata   = rand256();
         l2_rdata  = rand256();
         if (l2_read || l2_write) l2_resp = ($urandom_range(0, 2) == 0);
         else                     l2_resp = ($urandom_range(0, 7) == 0);
         model_step();
         tick();
         check_model(c);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/mem_req_scheduler.md
MEM_REQ_SCHEDULER -- requirements
Module: mem_req_scheduler

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: max consecutive dcache grants while an icache request waits (range 1..15).
REQ-002 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i_read  in  1  icache line-fill request.
REQ-005 SHALL have port i_address  in  32  icache line address.
REQ-006 SHALL have port i_resp  out  1  icache completion pulse.
REQ-007 SHALL have port i_rdata  out  256  icache fill line.
REQ-008 SHALL have port d_read  in  1  dcache line-fill request.
REQ-009 SHALL have port d_write  in  1  dcache write-back request.
REQ-010 SHALL have port d_address  in  32  dcache line address.
REQ-011 SHALL have port d_wdata  in  256  dcache write-back line.
REQ-012 SHALL have port d_resp  out  1  dcache completion pulse.
REQ-013 SHALL have port d_rdata  out  256  dcache fill line.
REQ-014 SHALL have port l2_read  out  1  L2 read request.
REQ-015 SHALL have port l2_write  out  1  L2 write request.
REQ-016 SHALL have port l2_address  out  32  L2 line address.
REQ-017 SHALL have port l2_wdata  out  256  L2 write line.
REQ-018 SHALL have port l2_resp  in  1  L2 completion.
REQ-019 SHALL have port l2_rdata  in  256  L2 read line.

Function
REQ-020 SHALL implement states IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
REQ-021 IDLE, only i_read pending: SHALL go to BUSY_I; only d_read/d_write pending: SHALL go to BUSY_D.
REQ-022 IDLE, both pending: SHALL grant dcache unless starve_cnt == STARVE_MAX, in which case SHALL grant icache.
REQ-023 starve_cnt SHALL increment (saturating at STARVE_MAX) on each dcache grant with i_read high, and clear to 0 on each icache grant or on a dcache grant with i_read low.
REQ-024 On grant, address, wdata and opcode SHALL be captured into registers; l2_* outputs SHALL be driven only from these registers (no combinational path from requester inputs to l2_*).
REQ-025 l2_read/l2_write SHALL assert the cycle after grant (first BUSY cycle) and hold, with l2_address/l2_wdata stable, until the cycle l2_resp is sampled high.
REQ-026 d_write high at grant SHALL issue l2_write; otherwise l2_read. d_read and d_write both high SHALL be treated as write.
REQ-027 l2_resp high in BUSY_x SHALL capture l2_rdata, deassert l2_read/l2_write the next cycle, and move to DONE_x.
REQ-028 DONE_x SHALL last exactly one cycle, pulse x_resp high for that cycle with x_rdata = captured line, then return to IDLE; no grant is made in DONE_x.
REQ-029 x_rdata SHALL hold its value outside DONE_x; dcache write completion SHALL leave d_rdata unchanged.
REQ-030 Latency: request seen in IDLE at cycle 0 -> l2 request cycle 1; l2_resp at cycle k -> x_resp cycle k+1 -> IDLE cycle k+2, earliest next l2 request cycle k+3.
REQ-031 Requester dropping its request during BUSY SHALL NOT abort; the L2 transaction completes and x_resp still pulses.
REQ-032 l2_resp while in IDLE or DONE_x SHALL be ignored.
REQ-033 At most one of l2_read, l2_write and at most one of i_resp, d_resp SHALL be high in any cycle.

Reset
REQ-034 rst high SHALL immediately force state IDLE, starve_cnt 0, all 1-bit outputs 0, l2_address 0, l2_wdata 0, i_rdata 0, d_rdata 0.
REQ-035 rst mid-transaction SHALL abandon the L2 request with no resp pulse; first grant is evaluated the first rising edge after rst deasserts.

Verification
REQ-036 i_read=1, i_address=0x0000_0060, L2 responds 3 cycles after l2_read with 0xA5.. line -> l2_read cycle 1 with address 0x60, i_resp one-cycle pulse, i_rdata=0xA5.. line.
REQ-037 d_write=1, d_address=0x8000_0020, d_wdata=0x1234.. -> l2_write high with matching address/data held until l2_resp; d_resp single pulse; l2_read never high.
REQ-038 i_read and d_read held high continuously, STARVE_MAX=4, L2 1-cycle resp -> grant order D,D,D,D,I, repeating; no icache wait exceeds 4 dcache grants.
REQ-039 d_read dropped the cycle after grant -> L2 read still completes, d_resp pulses once, next grant waits for IDLE.
REQ-040 rst asserted in BUSY_D with l2_read high -> l2_read 0 asynchronously, no d_resp, starve_cnt 0; post-reset i_read granted normally.
REQ-041 Spurious l2_resp in IDLE with no requests -> no resp pulse, state stays IDLE, outputs unchanged.
